key_onehot_latch: RTL and testbench

- Upstream front-end for the 8-to-3 priority encoder.
- Takes eight raw, asynchronous push-button lines, then synchronises, debounces and edge-detects them.
- Latches the winning key as a registered one-hot vector I[7:0] with enable E; these drive the encoder's I and E inputs directly.
- Gives the encoder a clean, stable, single-hot code that persists after the button is released.

---
 rtl/key_onehot_latch.sv | 153 +++++++++++++++
 tb/tb_key_onehot_latch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_onehot_latch.sv
// Key front-end: synchronise, debounce and edge-detect 8 buttons, latch the winner as one-hot I/E.
// Build option KEY_ACTIVE_LOW_EN: key_in lines are active-low (pressed = 0).
module key_onehot_latch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_in,
  input  logic       clr,
  output logic [7:0] I,
  output logic       E,
  output logic       new_pulse,
  output logic       busy
);

  // state   | meaning
  // IDLE    | nothing latched, I=0, E=0
  // HELD    | key captured and still physically down, new rises ignored
  // LATCHED | key captured and released, next rise replaces it
  typedef enum logic [1:0] {S_IDLE, S_HELD, S_LATCHED} state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]                   w_key;
  logic [SYNC_STAGES-1:0][7:0]  r_sync;
  logic [7:0]                   w_synced;
  logic [7:0][CW-1:0]           r_cnt;
  logic [7:0]                   r_deb;
  logic [7:0]                   r_deb_d;
  logic [7:0]                   w_rise;
  logic [7:0]                   w_win;
  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [7:0]                   r_i;
  logic [7:0]                   w_i_nxt;
  logic                         r_e;
  logic                         w_e_nxt;
  logic                         r_pulse;
  logic                         w_pulse_nxt;

`ifdef KEY_ACTIVE_LOW_EN
  assign w_key = ~key_in;
`else
  assign w_key = key_in;
`endif

  // Inversion happens before the chain, so reset to 0 is the released state in both builds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_key};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int b = 0; b < 8; b++) begin
        if (w_synced[b] == r_deb[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_LAST) begin
          r_deb[b] <= ~r_deb[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_rise = r_deb & ~r_deb_d;

  // Ascending scan: the highest rising index is the last to write.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_rise[i]) begin
        w_win    = '0;
        w_win[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_e_nxt     = r_e;
    w_pulse_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_i_nxt = '0;
        w_e_nxt = 1'b0;
        if (|w_rise) begin
          w_i_nxt     = w_win;
          w_e_nxt     = 1'b1;
          w_pulse_nxt = 1'b1;
          w_state_nxt = S_HELD;
        end
      end
      S_HELD: begin
        if (r_deb == 8'h00) w_state_nxt = S_LATCHED;
      end
      S_LATCHED: begin
        if (|w_rise) begin
          w_i_nxt     = w_win;
          w_e_nxt     = 1'b1;
          w_pulse_nxt = 1'b1;
          w_state_nxt = S_HELD;
        end
      end
      default: begin
        w_i_nxt     = '0;
        w_e_nxt     = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_i_nxt     = '0;
      w_e_nxt     = 1'b0;
      w_pulse_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_e     <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_e     <= w_e_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign I         = r_i;
  assign E         = r_e;
  assign new_pulse = r_pulse;
  assign busy      = (r_state == S_HELD);

endmodule

// File: tb/tb_key_onehot_latch.sv
// Scoreboard bench for key_onehot_latch: stimulus pushes expected captures, a monitor checks each pulse.
module tb_key_onehot_latch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key_in;
  logic       clr = 1'b0;
  logic [7:0] I;
  logic       E;
  logic       new_pulse;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] i;
  } exp_t;
  exp_t sb[$];

`ifdef KEY_ACTIVE_LOW_EN
  localparam logic [7:0] POL = 8'hFF;
`else
  localparam logic [7:0] POL = 8'h00;
`endif

  key_onehot_latch #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .clr(clr),
    .I(I), .E(E), .new_pulse(new_pulse), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Logical key vector; polarity handled here so scenarios are build-independent.
  task automatic drive(input logic [7:0] k);
    key_in = k ^ POL;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Capture is expected 6 edges after the first sampling edge, i.e. at cycle (now + 7).
  task automatic press_expect(input logic [7:0] k, input logic [7:0] win);
    exp_t e;
    drive(k);
    e.cyc = cyc + 7;
    e.i   = win;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_onehot", {31'd0, $countones(I) <= 1}, 32'd1);
      chk("inv_E", {31'd0, E}, {31'd0, I != 8'h00});
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_chk++;
        n_err++;
        $display("FAIL cap_missing: no pulse, expected I=%0h at cycle %0d", sb[0].i, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (new_pulse) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL pulse_unexpected: got pulse with I=%0h at cycle %0d, expected none", I, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("cap_I", {24'd0, I}, {24'd0, e.i});
          chk("cap_cycle", cyc, e.cyc);
          chk("cap_E", {31'd0, E}, 32'd1);
        end
      end
    end
  end

  initial begin
    int c;
    drive(8'hFF);
    wait_neg(3);
    chk("rst_I", {24'd0, I}, 32'h0);
    chk("rst_E", {31'd0, E}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulse", {31'd0, new_pulse}, 32'd0);

    // Release reset with all keys held: key 7 wins.
    rst_n = 1'b1;
    press_expect(8'hFF, 8'h80);
    wait_neg(10);
    chk("held_busy", {31'd0, busy}, 32'd1);
    drive(8'h00);
    c = cyc;
    wait_neg(6);
    chk("rel_busy_still", {31'd0, busy}, 32'd1);
    wait_neg(1);
    chk("rel_busy_drop", {31'd0, busy}, 32'd0);
    chk("rel_I_kept", {24'd0, I}, 32'h80);
    chk("rel_E_kept", {31'd0, E}, 32'd1);
    wait_neg(4);

    // Single press.
    press_expect(8'h04, 8'h04);
    wait_neg(10);
    drive(8'h00);
    wait_neg(6);
    chk("single_busy_still", {31'd0, busy}, 32'd1);
    wait_neg(1);
    chk("single_busy_drop", {31'd0, busy}, 32'd0);
    chk("single_I_kept", {24'd0, I}, 32'h04);
    wait_neg(4);

    // Bounce on key 3: 3 high / 1 low, never long enough to debounce.
    for (int r = 0; r < 4; r++) begin
      drive(8'h08);
      wait_neg(3);
      drive(8'h00);
      wait_neg(1);
    end
    chk("bounce_I", {24'd0, I}, 32'h04);
    press_expect(8'h08, 8'h08);
    wait_neg(10);
    drive(8'h00);
    wait_neg(10);

    // Simultaneous keys 6 and 0: 6 wins; re-pressing 0 during HELD is ignored.
    press_expect(8'h41, 8'h40);
    wait_neg(10);
    drive(8'h40);
    wait_neg(8);
    drive(8'h41);
    wait_neg(8);
    chk("sim_I", {24'd0, I}, 32'h40);
    chk("sim_busy", {31'd0, busy}, 32'd1);
    drive(8'h00);
    wait_neg(10);
    press_expect(8'h02, 8'h02);
    wait_neg(10);
    drive(8'h00);
    wait_neg(10);

    // Clear on the same edge key 5 would capture.
    drive(8'h20);
    wait_neg(6);
    clr = 1'b1;
    wait_neg(1);
    clr = 1'b0;
    chk("clr_I", {24'd0, I}, 32'h0);
    chk("clr_E", {31'd0, E}, 32'd0);
    chk("clr_pulse", {31'd0, new_pulse}, 32'd0);
    wait_neg(10);
    chk("clr_held_I", {24'd0, I}, 32'h0);
    chk("clr_held_busy", {31'd0, busy}, 32'd0);
    drive(8'h00);
    wait_neg(10);
    chk("clr_rel_I", {24'd0, I}, 32'h0);
    press_expect(8'h20, 8'h20);
    wait_neg(10);
    drive(8'h00);
    wait_neg(10);

    // Key 0 alone (pins 8'hFE in the active-low build).
    press_expect(8'h01, 8'h01);
    wait_neg(10);
    drive(8'h00);
    wait_neg(10);
    chk("final_I", {24'd0, I}, 32'h01);

    while (sb.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL cap_missing: no pulse, expected I=%0h at cycle %0d", sb[0].i, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
